// File: rtl/xts_tweak_gen.sv
// XTS tweak generator and whitening stage: pre-whitens data with the running tweak, advances it by alpha,
// and post-whitens AES results with the queued tweak. Optional XTS_BLOCK_LIMIT_EN stops a sector at 2^CNT_W-1 blocks.
module xts_tweak_gen #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inTweakWr,
  input  logic [127:0]     inTweak,
  input  logic             inPreValid,
  input  logic [127:0]     inPreData,
  output logic             outPreReady,
  output logic             outPreValid,
  output logic [127:0]     outPreData,
  input  logic             inPostValid,
  input  logic [127:0]     inPostData,
  output logic             outPostValid,
  output logic [127:0]     outPostData,
  output logic [CNT_W-1:0] outBlockCount,
  output logic             outBusy,
  output logic             outErr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state, state_next;
  logic [127:0]       tweak;
  logic [127:0]       fifo [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic               fifo_empty, fifo_full, at_limit;
  logic               load, accept, pop;

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == OCC_W'(DEPTH));
  assign outBusy    = !fifo_empty;

`ifdef XTS_BLOCK_LIMIT_EN
  assign at_limit = (outBlockCount == {CNT_W{1'b1}});
`else
  assign at_limit = 1'b0;
`endif

  // A tweak load takes priority over a block offered in the same cycle.
  assign load   = inTweakWr && fifo_empty;
  assign accept = inPreValid && outPreReady && !load;
  assign pop    = inPostValid && !fifo_empty;

  always_ff @(posedge inClk) begin
    if (inRst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load) state_next = ACTIVE;
  end

  // Readiness depends only on registered state, never on inPreValid.
  always_comb begin
    outPreReady = 1'b0;
    if (state == ACTIVE && !fifo_full && !at_limit) outPreReady = 1'b1;
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      tweak         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      outBlockCount <= '0;
      outPreValid   <= 1'b0;
      outPreData    <= '0;
      outPostValid  <= 1'b0;
      outPostData   <= '0;
      outErr        <= 1'b0;
    end else begin
      outPreValid  <= accept;
      outPostValid <= pop;
      if (accept) begin
        outPreData    <= inPreData ^ tweak;
        tweak         <= {tweak[126:0], 1'b0} ^ (tweak[127] ? 128'h87 : 128'h0);
        wr_ptr        <= wr_ptr + PTR_W'(1);
        outBlockCount <= outBlockCount + CNT_W'(1);
      end
      if (load) begin
        tweak         <= inTweak;
        outBlockCount <= '0;
      end
      if (pop) begin
        outPostData <= inPostData ^ fifo[rd_ptr];
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      if (accept && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !accept) occ <= occ - OCC_W'(1);
      if ((inTweakWr && !fifo_empty) || (inPostValid && fifo_empty)) outErr <= 1'b1;
    end
  end

  // Tweak storage needs no reset: entries are only read behind the pointers.
  always_ff @(posedge inClk) begin
    if (accept) fifo[wr_ptr] <= tweak;
  end

endmodule

// File: doc/xts_tweak_gen.md
# xts_tweak_gen

XTS tweak generator and whitening stage, directly downstream of the tweak-encryption AES pass (T = E_K2(sector index)) and wrapped around the data AES encrypt/decrypt core. Loads the encrypted tweak, XORs each incoming data block with its tweak before the AES core (pre-whitening), and advances the tweak by multiplication by alpha in GF(2^128). Holds issued tweaks in a small FIFO so each AES result is post-whitened with the tweak it was pre-whitened with.

## Interface
- DEPTH, 4: tweak FIFO entries, i.e. blocks in flight in the AES core; power of two, 2..16.
- CNT_W, 8: width of the per-sector block counter.

- inClk  in  1  clock, all logic on rising edge.
- inRst  in  1  synchronous, active-high reset.
- inTweakWr  in  1  one-cycle strobe: load inTweak as tweak for block 0 of a new sector.
- inTweak  in  128  encrypted tweak, little-endian integer: byte j at bits [8j+7:8j].
- inPreValid  in  1  data block (plaintext or ciphertext) offered.
- inPreData  in  128  data block.
- outPreReady  out  1  block accepted in a cycle where inPreValid & outPreReady.
- outPreValid  out  1  one-cycle pulse: outPreData valid for the AES core.
- outPreData  out  128  inPreData ^ current tweak.
- inPostValid  in  1  one-cycle pulse: AES core result available.
- inPostData  in  128  AES core result.
- outPostValid  out  1  one-cycle pulse: outPostData valid.
- outPostData  out  128  inPostData ^ FIFO head tweak.
- outBlockCount  out  CNT_W  blocks accepted since last tweak load.
- outBusy  out  1  FIFO non-empty.
- outErr  out  1  sticky protocol error; cleared only by inRst.

## Operation
- States: IDLE (no tweak loaded), ACTIVE. Reset -> IDLE.
- inTweakWr accepted only when FIFO empty: T <= inTweak, outBlockCount <= 0, state -> ACTIVE. Allowed from IDLE or ACTIVE (restarts sector). inTweakWr with FIFO non-empty: ignored, outErr <= 1.
- outPreReady = ACTIVE & FIFO not full & not block-limit (see Configuration). Combinational from registered state only; never from inPreValid.
- Accept: outPreData <= inPreData ^ T; push T to FIFO; T <= {T[126:0],1'b0} ^ (T[127] ? 128'h87 : 128'h0); outBlockCount increments.
- inTweakWr and accept in the same cycle: tweak load wins; block not accepted (outPreReady is don't-care to the source that cycle, which must hold inPreValid).
- inPostValid with FIFO non-empty: outPostData <= inPostData ^ head; pop. With FIFO empty: no output pulse, outErr <= 1.
- Push and pop in the same cycle: both occur; occupancy unchanged. Full status for outPreReady uses pre-cycle occupancy (no same-cycle pass-through).
- FIFO pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.

## Timing
- Reset values: outPreReady 0, outPreValid 0, outPreData 0, outPostValid 0, outPostData 0, outBlockCount 0, outBusy 0, outErr 0; T 0, FIFO empty, state IDLE.
- inTweakWr at cycle n -> outPreReady may be 1 at n+1.
- Accept at cycle n -> outPreValid=1 and outPreData valid at n+1 only; back-to-back accepts give back-to-back pulses.
- inPostValid at cycle n -> outPostValid at n+1 only.
- outBusy reflects occupancy after the cycle's push/pop.
- inRst mid-operation: all state cleared next edge; in-flight tweaks discarded; later inPostValid flags outErr.

## Configuration
- XTS_BLOCK_LIMIT_EN defined: outPreReady forced 0 once outBlockCount == 2^CNT_W-1; further blocks of the sector refused until next inTweakWr.
- Not defined: outBlockCount wraps 2^CNT_W-1 -> 0 and acceptance continues; tweak keeps advancing.

## Test plan
- Load inTweak=128'h1, send three blocks of 0 -> outPreData 128'h1, 128'h2, 128'h4 on consecutive cycles; outBlockCount=3.
- Load 128'h8000_0000_0000_0000_0000_0000_0000_0000, send two zero blocks -> outPreData equals tweak, then 128'h87.
- DEPTH=4, five back-to-back blocks, no post -> 4 accepted, outPreReady 0, outBusy 1; one inPostValid with data 0 -> outPostData = first tweak, outPreReady 1 next cycle.
- inPostValid with FIFO empty -> no outPostValid, outErr=1 and stays 1; inTweakWr while outBusy=1 -> ignored, outErr=1.
- CNT_W=2 with XTS_BLOCK_LIMIT_EN: after 3 accepts outPreReady 0; without macro: 4th accepted, outBlockCount 0.
- inRst asserted with 2 blocks in flight -> next cycle all outputs 0, state IDLE, outPreReady 0.
